// File: rtl/game_flow_pkg.sv
// Shared types and helpers for the snake game-flow sequencer.
// The state encoding is one-hot; each bit drives one screen flag directly.
package game_flow_pkg;

  localparam int ST_W = 7;

  typedef enum logic [ST_W-1:0] {
    ST_READY = 7'b000_0001,
    ST_PLAY  = 7'b000_0010,
    ST_PAUSE = 7'b000_0100,
    ST_DIED  = 7'b000_1000,
    ST_LVLUP = 7'b001_0000,
    ST_WIN   = 7'b010_0000,
    ST_OVER  = 7'b100_0000
  } state_e;

  // A single level still needs a one-bit level port.
  function automatic int lvl_width(input int levels);
    return (levels > 1) ? $clog2(levels) : 1;
  endfunction

  function automatic int life_width(input int lives);
    return $clog2(lives + 1);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_btn_edge_sync.sv
// Two-flop synchroniser for an active-low button pin, followed by a
// falling-edge detector that emits a one-cycle press pulse.
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= btn_n;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign press = prev_q & ~sync_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: levels, lives, pause and a held result screen.
// Define AUTO_RESTART_EN to leave WIN/OVER automatically once the hold expires.
module game_flow_ctrl
  import game_flow_pkg::*;
#(
  parameter  int LEVELS      = 4,
  parameter  int LIVES       = 3,
  parameter  int RESULT_HOLD = 25000000,
  localparam int LVL_W       = lvl_width(LEVELS),
  localparam int LIFE_W      = life_width(LIVES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enter_n,
  input  logic              pause_n,
  input  logic              over,
  input  logic              win,
  output logic              ready_sig,
  output logic              start,
  output logic              pause_sig,
  output logic              died_sig,
  output logic              lvlup_sig,
  output logic              win_sig,
  output logic              over_sig,
  output logic [LVL_W-1:0]  level,
  output logic [LIFE_W-1:0] lives,
  output logic              level_load
);

  localparam int                HOLD_W    = $clog2(RESULT_HOLD + 1);
  localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(LEVELS - 1);
  localparam logic [LIFE_W-1:0] LIFE_FULL = LIFE_W'(LIVES);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(RESULT_HOLD);

  logic enter_press;
  logic pause_press;

  btn_edge_sync u_enter_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (enter_n),
    .press (enter_press)
  );

  btn_edge_sync u_pause_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (pause_n),
    .press (pause_press)
  );

  state_e              state_q, state_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [LIFE_W-1:0]   lives_q, lives_d;
  logic [HOLD_W-1:0]   hold_q,  hold_d;
  logic                load_q,  load_d;
  logic                hold_sat;
  logic                restart;

  assign hold_sat = (hold_q == HOLD_SAT);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    hold_d  = '0;
    load_d  = 1'b0;
    restart = 1'b0;

    case (state_q)
      ST_READY: begin
        if (enter_press) begin
          state_d = ST_PLAY;
          level_d = '0;
          lives_d = LIFE_FULL;
          load_d  = 1'b1;
        end
      end

      ST_PLAY: begin
        if (over) begin
          if (lives_q > LIFE_W'(1)) begin
            state_d = ST_DIED;
            lives_d = lives_q - LIFE_W'(1);
          end else begin
            state_d = ST_OVER;
            lives_d = '0;
          end
        end else if (win) begin
          state_d = (level_q < LVL_MAX) ? ST_LVLUP : ST_WIN;
        end else if (pause_press) begin
          state_d = ST_PAUSE;
        end
      end

      // Resuming from pause continues the same level, so no reload pulse.
      ST_PAUSE: begin
        if (enter_press || pause_press) begin
          state_d = ST_PLAY;
        end
      end

      ST_DIED: begin
        if (enter_press) begin
          state_d = ST_PLAY;
          load_d  = 1'b1;
        end
      end

      ST_LVLUP: begin
        if (enter_press) begin
          state_d = ST_PLAY;
          level_d = (level_q < LVL_MAX) ? level_q + LVL_W'(1) : level_q;
          load_d  = 1'b1;
        end
      end

      ST_WIN, ST_OVER: begin
        hold_d = hold_sat ? hold_q : hold_q + HOLD_W'(1);
`ifdef AUTO_RESTART_EN
        restart = hold_sat;
`else
        restart = hold_sat && enter_press;
`endif
        if (restart) begin
          state_d = ST_READY;
          level_d = '0;
          lives_d = LIFE_FULL;
        end
      end

      default: begin
        state_d = ST_READY;
        level_d = '0;
        lives_d = LIFE_FULL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_READY;
      level_q <= '0;
      lives_q <= LIFE_FULL;
      hold_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      lives_q <= lives_d;
      hold_q  <= hold_d;
      load_q  <= load_d;
    end
  end

  // One-hot state bits are the screen flags, straight from the flops.
  assign {over_sig, win_sig, lvlup_sig, died_sig, pause_sig, start, ready_sig} = state_q;
  assign level      = level_q;
  assign lives      = lives_q;
  assign level_load = load_q;

endmodule
